// File: rtl/alu_pkg.sv
// Shared width constant and operation encodings for the Y86 execute-stage ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_flags.sv
// Combinational condition-code generation (ZF, SF, OF) from operands, raw result and op.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_res,
  input  alu_op_e          i_op,
  output logic             o_zf,
  output logic             o_sf,
  output logic             o_of
);

  logic w_sa, w_sb, w_sr;

  assign w_sa = i_a[WIDTH-1];
  assign w_sb = i_b[WIDTH-1];
  assign w_sr = i_res[WIDTH-1];

  assign o_zf = (i_res == '0);
  assign o_sf = w_sr;

  // Signed overflow: the operands' effective signs agree but the result sign differs.
  always_comb begin
    o_of = 1'b0;
    case (i_op)
      ALU_ADD: o_of = (w_sa == w_sb) && (w_sr != w_sa);
      ALU_SUB: o_of = (w_sa != w_sb) && (w_sr != w_sa);
      default: o_of = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered Y86 execute-stage ALU with start-edge handshake and done flag.
// Optional ALU_TRACE_DISPLAY_EN adds a simulation trace when done rises.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             done,
  output logic [2:0]       cc,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic             r_start_q;
  logic             r_busy;
  logic [WIDTH-1:0] r_a, r_b, r_out;
  alu_op_e          r_sel;
  logic             r_zf, r_sf, r_of, r_done;

  logic             w_start_edge;
  logic [WIDTH-1:0] w_result;
  logic             w_zf, w_sf, w_of;

  assign w_start_edge = start && !r_start_q;

  always_comb begin
    w_result = '0;
    case (r_sel)
      ALU_ADD: w_result = r_a + r_b;
      ALU_SUB: w_result = r_a - r_b;
      ALU_AND: w_result = r_a & r_b;
      ALU_XOR: w_result = r_a ^ r_b;
      default: w_result = '0;
    endcase
  end

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_res(w_result),
    .i_op (r_sel),
    .o_zf (w_zf),
    .o_sf (w_sf),
    .o_of (w_of)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_busy    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= ALU_ADD;
      r_out     <= '0;
      r_zf      <= 1'b0;
      r_sf      <= 1'b0;
      r_of      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_busy    <= w_start_edge;
      if (r_busy) begin
        r_out  <= w_result;
        r_zf   <= w_zf;
        r_sf   <= w_sf;
        r_of   <= w_of;
        r_done <= 1'b1;
      end
      // NOTE: with non-blocking assignments the last write in the block wins, so a
      // back-to-back start edge overrides the completing op's done<=1.
      if (w_start_edge) begin
        r_a    <= a;
        r_b    <= b;
        r_sel  <= alu_op_e'(sel);
        r_done <= 1'b0;
      end
    end
  end

  assign out      = r_out;
  assign zf       = r_zf;
  assign sf       = r_sf;
  assign of       = r_of;
  assign overflow = r_of;
  assign cc       = {r_zf, r_sf, r_of};
  assign done     = r_done;

`ifdef ALU_TRACE_DISPLAY_EN
  always @(posedge clk) begin
    if (!rst && r_busy && !w_start_edge)
      $display("alu: sel=%0d a=%h b=%h out=%h zsf=%b%b%b",
               r_sel, r_a, r_b, w_result, w_zf, w_sf, w_of);
  end
`else
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor checks each done rise.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a = '0, b = '0;
  logic [1:0]  sel = '0;
  logic        start = 1'b0;
  logic [63:0] out;
  logic        overflow, done, zf, sf, of;
  logic [2:0]  cc;

  alu dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .start(start),
    .out(out), .overflow(overflow), .done(done), .cc(cc),
    .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] out;
    logic [2:0]  cc;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rises = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every 0->1 transition on done consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && done && !prev_done) begin
      rises++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=rise expected=none out=%h", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_out"}, out, e.out);
        check({e.name, "_cc"}, 64'(cc), 64'(e.cc));
        check({e.name, "_flags"}, 64'({zf, sf, of}), 64'(e.cc));
        check({e.name, "_overflow"}, 64'(overflow), 64'(e.cc[0]));
        check({e.name, "_latency"}, 64'(cyc - e.issue), 64'd2);
      end
    end
    prev_done = done;
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
      sb.delete();
    end
  endtask

  task automatic do_op(input string name, input alu_op_e op, input logic [63:0] ia,
                       input logic [63:0] ib, input logic [63:0] eo, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; sel = op; start = 1'b1;
    e.name = name; e.out = eo; e.cc = ec; e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
    // Operands captured on the edge just passed; scrambling them must not matter.
    start = 1'b0; a = ~ia ^ 64'h5A5A; b = ib + 64'd77; sel = ~sel;
    wait_drain(name);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    exp_t e;
    repeat (3) @(negedge clk);
    check("reset_out", out, 64'd0);
    check("reset_cc", 64'(cc), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_5_3",   ALU_ADD, 64'd5, 64'd3, 64'd8, 3'b000);
    do_op("sub_8_8",   ALU_SUB, 64'd8, 64'd8, 64'd0, 3'b100);
    do_op("sub_0_1",   ALU_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    do_op("add_ovf",   ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b011);
    do_op("sub_ovf",   ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
    do_op("and",       ALU_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 3'b000);
    do_op("xor_same",  ALU_XOR, 64'h1234, 64'h1234, 64'd0, 3'b100);
    do_op("sub_order", ALU_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010);
    do_op("add_ovf2",  ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b011);

    // Held-high start: exactly one operation (carry-out discarded).
    @(negedge clk);
    r0 = rises;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; sel = ALU_ADD; start = 1'b1;
    e.name = "held_start"; e.out = 64'd0; e.cc = 3'b100; e.issue = cyc;
    sb.push_back(e);
    repeat (10) @(negedge clk);
    start = 1'b0;
    check("held_start_rises", 64'(rises - r0), 64'd1);
    wait_drain("held_start");
    @(negedge clk);

    // Reset between start edge and done: outputs clear immediately, no done follows.
    do_op("pre_reset", ALU_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    @(negedge clk);
    a = 64'd9; b = 64'd4; sel = ALU_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_out", out, 64'd0);
    check("midrst_cc", 64'(cc), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    r0 = rises;
    repeat (5) @(negedge clk);
    check("midrst_no_done", 64'(rises - r0), 64'd0);

    do_op("post_reset", ALU_ADD, 64'd5, 64'd3, 64'd8, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
